// File: rtl/juice_vend_machine.sv
// rtl/juice_vend_machine.sv - coin-accumulating juice vending controller
// Optional JUICE_CHANGE_AMT_EN adds the change_amt output.
module juice_vend_machine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] dollar,
  output logic       juice_1,
  output logic       juice_2,
  output logic       return_change
`ifdef JUICE_CHANGE_AMT_EN
  ,
  output logic [2:0] change_amt
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ONE  = 1'b1;

  localparam logic [2:0] PRICE_1 = 3'd2;
  localparam logic [2:0] PRICE_2 = 3'd5;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [2:0] coin_val;
  logic [2:0] sum;
  logic [2:0] change;
  logic       juice_1_nxt;
  logic       juice_2_nxt;

  // Invalid codes decode to zero value so they behave exactly like "no coin".
  always_comb begin
    coin_val = 3'd0;
    case (dollar)
      3'b001:  coin_val = 3'd1;
      3'b010:  coin_val = 3'd2;
      3'b011:  coin_val = 3'd5;
      default: coin_val = 3'd0;
    endcase
  end

  assign sum = {2'b00, state} + coin_val;

  always_comb begin
    state_nxt   = state;
    juice_1_nxt = 1'b0;
    juice_2_nxt = 1'b0;
    change      = 3'd0;
    if (coin_val == PRICE_2) begin
      juice_2_nxt = 1'b1;
      change      = sum - PRICE_2;
      state_nxt   = IDLE;
    end else if (sum >= PRICE_1) begin
      juice_1_nxt = 1'b1;
      change      = sum - PRICE_1;
      state_nxt   = IDLE;
    end else if (coin_val != 3'd0) begin
      state_nxt   = ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      juice_1       <= 1'b0;
      juice_2       <= 1'b0;
      return_change <= 1'b0;
    end else begin
      state         <= state_nxt;
      juice_1       <= juice_1_nxt;
      juice_2       <= juice_2_nxt;
      return_change <= (change != 3'd0);
    end
  end

`ifdef JUICE_CHANGE_AMT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_amt <= 3'd0;
    end else begin
      change_amt <= change;
    end
  end
`endif

endmodule

// File: tb/tb_juice_vend_machine.sv
// tb/tb_juice_vend_machine.sv - directed self-checking bench for juice_vend_machine
module tb_juice_vend_machine;

  logic       clk;
  logic       rst_n;
  logic [2:0] dollar;
  logic       juice_1;
  logic       juice_2;
  logic       return_change;
`ifdef JUICE_CHANGE_AMT_EN
  logic [2:0] change_amt;
`endif

  int n_cmp;
  int n_bad;

  juice_vend_machine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dollar        (dollar),
    .juice_1       (juice_1),
    .juice_2       (juice_2),
    .return_change (return_change)
`ifdef JUICE_CHANGE_AMT_EN
    ,
    .change_amt    (change_amt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one coin code for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic coin(input logic [2:0] code);
    dollar = code;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    dollar = 3'b000;
    #12;
    n_cmp++; if (juice_1 !== 1'b0) begin n_bad++; $display("FAIL reset_j1 got %b want 0", juice_1); end
    n_cmp++; if (juice_2 !== 1'b0) begin n_bad++; $display("FAIL reset_j2 got %b want 0", juice_2); end
    n_cmp++; if (return_change !== 1'b0) begin n_bad++; $display("FAIL reset_rc got %b want 0", return_change); end
`ifdef JUICE_CHANGE_AMT_EN
    n_cmp++; if (change_amt !== 3'd0) begin n_bad++; $display("FAIL reset_amt got %0d want 0", change_amt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_two_ones;
    coin(3'b001);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b000) begin n_bad++; $display("FAIL ones_first got %b want 000", {juice_1, juice_2, return_change}); end
    coin(3'b001);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b100) begin n_bad++; $display("FAIL ones_second got %b want 100", {juice_1, juice_2, return_change}); end
    coin(3'b000);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b000) begin n_bad++; $display("FAIL ones_width got %b want 000", {juice_1, juice_2, return_change}); end
  endtask

  task automatic test_two_dollar;
    coin(3'b010);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b100) begin n_bad++; $display("FAIL two_pulse got %b want 100", {juice_1, juice_2, return_change}); end
    coin(3'b000);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b000) begin n_bad++; $display("FAIL two_width got %b want 000", {juice_1, juice_2, return_change}); end
  endtask

  task automatic test_five_dollar;
    coin(3'b011);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b010) begin n_bad++; $display("FAIL five_pulse got %b want 010", {juice_1, juice_2, return_change}); end
    coin(3'b000);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b000) begin n_bad++; $display("FAIL five_width got %b want 000", {juice_1, juice_2, return_change}); end
  endtask

  task automatic test_change;
    coin(3'b001);
    coin(3'b011);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b011) begin n_bad++; $display("FAIL change_six got %b want 011", {juice_1, juice_2, return_change}); end
`ifdef JUICE_CHANGE_AMT_EN
    n_cmp++; if (change_amt !== 3'd1) begin n_bad++; $display("FAIL change_six_amt got %0d want 1", change_amt); end
`endif
    coin(3'b001);
`ifdef JUICE_CHANGE_AMT_EN
    n_cmp++; if (change_amt !== 3'd0) begin n_bad++; $display("FAIL change_amt_idle got %0d want 0", change_amt); end
`endif
    coin(3'b010);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b101) begin n_bad++; $display("FAIL change_three got %b want 101", {juice_1, juice_2, return_change}); end
`ifdef JUICE_CHANGE_AMT_EN
    n_cmp++; if (change_amt !== 3'd1) begin n_bad++; $display("FAIL change_three_amt got %0d want 1", change_amt); end
`endif
    coin(3'b000);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b000) begin n_bad++; $display("FAIL change_width got %b want 000", {juice_1, juice_2, return_change}); end
  endtask

  task automatic test_invalid;
    logic [2:0] bad_codes [4];
    bad_codes = '{3'b101, 3'b111, 3'b100, 3'b110};
    for (int i = 0; i < 4; i++) begin
      coin(bad_codes[i]);
      n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b000) begin n_bad++; $display("FAIL invalid_idle code %b got %b want 000", bad_codes[i], {juice_1, juice_2, return_change}); end
    end
    // IDLE must still be IDLE: a single $1 gives no pulse.
    coin(3'b001);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b000) begin n_bad++; $display("FAIL invalid_idle_kept got %b want 000", {juice_1, juice_2, return_change}); end
    for (int i = 0; i < 2; i++) begin
      coin(bad_codes[i]);
      n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b000) begin n_bad++; $display("FAIL invalid_one code %b got %b want 000", bad_codes[i], {juice_1, juice_2, return_change}); end
    end
    coin(3'b001);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b100) begin n_bad++; $display("FAIL invalid_one_kept got %b want 100", {juice_1, juice_2, return_change}); end
    coin(3'b000);
  endtask

  task automatic test_async_reset;
    // Reset while a pulse is high must clear it without a clock edge.
    coin(3'b001);
    coin(3'b011);
    dollar = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b000) begin n_bad++; $display("FAIL async_clear got %b want 000", {juice_1, juice_2, return_change}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Held $1 credit must be discarded by reset.
    coin(3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b000) begin n_bad++; $display("FAIL async_one got %b want 000", {juice_1, juice_2, return_change}); end
    @(negedge clk);
    rst_n = 1'b1;
    coin(3'b010);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b100) begin n_bad++; $display("FAIL async_credit_cleared got %b want 100", {juice_1, juice_2, return_change}); end
    coin(3'b000);
  endtask

  task automatic test_back_to_back;
    logic [2:0] codes [7];
    logic [2:0] expect_out [7];
    codes      = '{3'b010, 3'b010, 3'b011, 3'b001, 3'b001, 3'b001, 3'b011};
    expect_out = '{3'b100, 3'b100, 3'b010, 3'b000, 3'b100, 3'b000, 3'b011};
    for (int i = 0; i < 7; i++) begin
      coin(codes[i]);
      n_cmp++; if ({juice_1, juice_2, return_change} !== expect_out[i]) begin n_bad++; $display("FAIL b2b step %0d got %b want %b", i, {juice_1, juice_2, return_change}, expect_out[i]); end
    end
    coin(3'b000);
    n_cmp++; if ({juice_1, juice_2, return_change} !== 3'b000) begin n_bad++; $display("FAIL b2b_tail got %b want 000", {juice_1, juice_2, return_change}); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_two_ones();
    test_two_dollar();
    test_five_dollar();
    test_change();
    test_invalid();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
